// File: rtl/overcurrent_guard_if.sv
// rtl/overcurrent_guard_if.sv - sense/enable bundle between comparators and the H-bridge enables
interface overcurrent_guard_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] oc_in;
    logic                clear;
    logic [CHANNELS-1:0] en_out;
    logic [CHANNELS-1:0] tripped;
    logic [CHANNELS-1:0] latched;

    modport master (
        output oc_in,
        output clear,
        input  en_out,
        input  tripped,
        input  latched
    );

    modport slave (
        input  oc_in,
        input  clear,
        output en_out,
        output tripped,
        output latched
    );
endinterface

// File: rtl/overcurrent_guard.sv
// rtl/overcurrent_guard.sv - per-channel windowed overcurrent debounce with cooldown, retry and lockout
module overcurrent_guard #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 40000000,
    parameter int WINDOW_CYCLES   = 100000000,
    parameter int COOLDOWN_CYCLES = 300000000,
    parameter int MAX_RETRIES     = 3,
    parameter int GROUP_TRIP      = 1
) (
    input  logic                clk,
    input  logic                rst,
    overcurrent_guard_if.slave  bus
);
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int HIT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int RTY_W  = $clog2(MAX_RETRIES + 2);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRIES);

    localparam logic [1:0] ARMED    = 2'd0;
    localparam logic [1:0] COOLDOWN = 2'd1;
    localparam logic [1:0] LOCKOUT  = 2'd2;

    logic [1:0]        state     [CHANNELS];
    logic [1:0]        state_nxt [CHANNELS];
    logic [WIN_W-1:0]  win_cnt   [CHANNELS];
    logic [WIN_W-1:0]  win_nxt   [CHANNELS];
    logic [HIT_W-1:0]  hit_cnt   [CHANNELS];
    logic [HIT_W-1:0]  hit_nxt   [CHANNELS];
    logic [COOL_W-1:0] cool_cnt  [CHANNELS];
    logic [COOL_W-1:0] cool_nxt  [CHANNELS];
    logic [RTY_W-1:0]  rty_cnt   [CHANNELS];
    logic [RTY_W-1:0]  rty_nxt   [CHANNELS];
    logic [CHANNELS-1:0] raw_en;

    always_comb begin
        raw_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state[i];
            win_nxt[i]   = win_cnt[i];
            hit_nxt[i]   = hit_cnt[i];
            cool_nxt[i]  = cool_cnt[i];
            rty_nxt[i]   = rty_cnt[i];
            if (bus.clear) begin
                state_nxt[i] = ARMED;
                win_nxt[i]   = '0;
                hit_nxt[i]   = '0;
                cool_nxt[i]  = '0;
                rty_nxt[i]   = '0;
            end else begin
                case (state[i])
                    ARMED: begin
                        // A trip outranks the window wrap that may land on the same clock.
                        if (bus.oc_in[i] && (hit_cnt[i] == HIT_LAST)) begin
                            rty_nxt[i]   = rty_cnt[i] + RTY_W'(1);
                            state_nxt[i] = ((rty_cnt[i] + RTY_W'(1)) > RTY_MAX) ? LOCKOUT : COOLDOWN;
                            win_nxt[i]   = '0;
                            hit_nxt[i]   = '0;
                            cool_nxt[i]  = '0;
                        end else if (win_cnt[i] == WIN_LAST) begin
                            win_nxt[i] = '0;
                            hit_nxt[i] = '0;
                            if ((hit_cnt[i] == '0) && !bus.oc_in[i])
                                rty_nxt[i] = '0;
                        end else begin
                            win_nxt[i] = win_cnt[i] + WIN_W'(1);
                            if (bus.oc_in[i])
                                hit_nxt[i] = hit_cnt[i] + HIT_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        if (cool_cnt[i] == COOL_LAST) begin
                            state_nxt[i] = ARMED;
                            win_nxt[i]   = '0;
                            hit_nxt[i]   = '0;
                            cool_nxt[i]  = '0;
                        end else begin
                            cool_nxt[i] = cool_cnt[i] + COOL_W'(1);
                        end
                    end
                    LOCKOUT: state_nxt[i] = LOCKOUT;
                    default: state_nxt[i] = ARMED;
                endcase
            end
            raw_en[i] = (state_nxt[i] == ARMED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]    <= ARMED;
                win_cnt[i]  <= '0;
                hit_cnt[i]  <= '0;
                cool_cnt[i] <= '0;
                rty_cnt[i]  <= '0;
            end
            bus.en_out  <= '1;
            bus.tripped <= '0;
            bus.latched <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]           <= state_nxt[i];
                win_cnt[i]         <= win_nxt[i];
                hit_cnt[i]         <= hit_nxt[i];
                cool_cnt[i]        <= cool_nxt[i];
                rty_cnt[i]         <= rty_nxt[i];
                bus.tripped[i]     <= (state_nxt[i] == COOLDOWN);
                bus.latched[i]     <= (state_nxt[i] == LOCKOUT);
            end
            bus.en_out <= (GROUP_TRIP != 0) ? {CHANNELS{&raw_en}} : raw_en;
        end
    end
endmodule
